// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised up/down counter.
package counter_pkg;

  typedef enum logic [1:0] {
    M_WRAP    = 2'd0,
    M_SAT     = 2'd1,
    M_BOUNCE  = 2'd2,
    M_ONESHOT = 2'd3
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value and boundary unit for one enabled counter step.
module counter_step
  import counter_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] count,
  input  logic [BIT_WIDTH-1:0] limit,
  input  logic                 dir,
  input  mode_t                mode,
  output logic [BIT_WIDTH-1:0] next_count,
  output logic                 next_dir,
  output logic                 hit_tc,
  output logic                 wrap_evt,
  output logic                 oneshot_end
);

  logic [BIT_WIDTH-1:0] term;

  // Terminal value for the current direction.
  assign term = (dir == DIR_DOWN) ? '0 : limit;

  // Work out the result of one step; the clamp case has priority over mode behaviour.
  always_comb begin
    next_count  = count;
    next_dir    = dir;
    hit_tc      = 1'b0;
    wrap_evt    = 1'b0;
    oneshot_end = 1'b0;
    if (count > limit) begin
      // Limit was lowered below the current count.
      next_count = limit;
      hit_tc     = 1'b1;
    end else if (count != term) begin
      next_count = (dir == DIR_DOWN) ? count - BIT_WIDTH'(1) : count + BIT_WIDTH'(1);
      hit_tc     = (next_count == term);
    end else begin
      unique case (mode)
        M_WRAP: begin
          next_count = (dir == DIR_DOWN) ? limit : '0;
          wrap_evt   = 1'b1;
        end
        M_SAT: begin
          next_count = count;
        end
        M_BOUNCE: begin
          next_dir = ~dir;
          wrap_evt = 1'b1;
          // With limit 0 there is nowhere to bounce to; count stays at 0.
          if (limit == '0) begin
            next_count = '0;
          end else begin
            next_count = (dir == DIR_DOWN) ? BIT_WIDTH'(1) : limit - BIT_WIDTH'(1);
          end
        end
        M_ONESHOT: begin
          oneshot_end = 1'b1;
        end
        default: begin
          next_count = count;
        end
      endcase
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised load/direction counter with modulo limit, run modes, terminal-count
// pulse and a saturating wrap-event counter.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned WRAP_W    = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 chnge,
  input  logic                 load_en,
  input  logic [BIT_WIDTH-1:0] load,
  input  logic [BIT_WIDTH-1:0] limit,
  input  logic [1:0]           mode,
  output logic [BIT_WIDTH-1:0] count,
  output logic                 dir,
  output logic                 tc,
  output logic                 done,
  output logic [WRAP_W-1:0]    wraps
);

  logic [BIT_WIDTH-1:0] count_q, count_d;
  logic                 dir_q, dir_d;
  logic                 tc_q, tc_d;
  state_t               state_q, state_d;
  logic [WRAP_W-1:0]    wraps_q, wraps_d;

  mode_t                mode_in;
  logic [BIT_WIDTH-1:0] step_count;
  logic                 step_dir;
  logic                 step_tc;
  logic                 step_wrap;
  logic                 step_end;

  assign mode_in = mode_t'(mode);

  // The step unit sees the registered direction, so a chnge edge takes effect one step later.
  counter_step #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_step (
    .count       (count_q),
    .limit       (limit),
    .dir         (dir_q),
    .mode        (mode_in),
    .next_count  (step_count),
    .next_dir    (step_dir),
    .hit_tc      (step_tc),
    .wrap_evt    (step_wrap),
    .oneshot_end (step_end)
  );

  // Next-state: load beats step beats hold (reset is applied in the register block).
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    state_d = state_q;
    wraps_d = wraps_q;
    if (load_en) begin
      count_d = (load > limit) ? limit : load;
      dir_d   = chnge;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      // Bounce owns its direction; the other modes track chnge every cycle.
      if (mode_in != M_BOUNCE) begin
        dir_d = chnge;
      end
      if (en) begin
        count_d = step_count;
        tc_d    = step_tc;
        if (mode_in == M_BOUNCE) begin
          dir_d = step_dir;
        end
        if (step_wrap && (wraps_q != '1)) begin
          wraps_d = wraps_q + WRAP_W'(1);
        end
        if (step_end) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= chnge;
      tc_q    <= 1'b0;
      state_q <= ST_RUN;
      wraps_q <= '0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      state_q <= state_d;
      wraps_q <= wraps_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;
  assign done  = (state_q == ST_DONE);
  assign wraps = wraps_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: directed vector table plus randomised run against a reference model.
module tb_updown_counter_mod;

  logic       CLK = 1'b0;
  logic       reset = 1'b0, en = 1'b0, chnge = 1'b0, load_en = 1'b0;
  logic [3:0] load = '0, limit = '0;
  logic [1:0] mode = '0;
  logic [3:0] count, count2;
  logic       dir, tc, done, dir2, tc2, done2;
  logic [7:0] wraps;
  logic [1:0] wraps2;

  int n_checks = 0;
  int n_fail   = 0;

  updown_counter_mod #(.BIT_WIDTH(4), .WRAP_W(8)) dut (
    .CLK(CLK), .reset(reset), .en(en), .chnge(chnge), .load_en(load_en), .load(load),
    .limit(limit), .mode(mode), .count(count), .dir(dir), .tc(tc), .done(done), .wraps(wraps)
  );

  updown_counter_mod #(.BIT_WIDTH(4), .WRAP_W(2)) dut2 (
    .CLK(CLK), .reset(reset), .en(en), .chnge(chnge), .load_en(load_en), .load(load),
    .limit(limit), .mode(mode), .count(count2), .dir(dir2), .tc(tc2), .done(done2),
    .wraps(wraps2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, ld;
    logic [3:0] ldv;
    logic       en, ch;
    logic [3:0] lim;
    logic [1:0] md;
    logic [3:0] cnt;
    logic       tc, dir, done;
    logic [7:0] wr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ld, input int ldv, input logic e,
                     input logic ch, input int lim, input int md, input int cnt,
                     input logic t, input logic d, input logic dn, input int wr);
    vec_t v;
    v.rst = rst; v.ld = ld; v.ldv = 4'(ldv); v.en = e; v.ch = ch; v.lim = 4'(lim);
    v.md = 2'(md); v.cnt = 4'(cnt); v.tc = t; v.dir = d; v.done = dn; v.wr = 8'(wr);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (count,tc,dir,done,wraps)", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [3:0] ldv, input logic e,
                       input logic ch, input logic [3:0] lim, input logic [1:0] md);
    reset = rst; load_en = ld; load = ldv; en = e; chnge = ch; limit = lim; mode = md;
    @(posedge CLK);
    #1;
  endtask

  // Reference model state (plain integers, spec rules applied directly)
  int m_cnt, m_dir, m_tc, m_done, m_wr, m_wr2;

  task automatic model(input int rst, input int ld, input int ldv, input int e, input int ch,
                       input int lim, input int md);
    int nd, tgt;
    if (rst != 0) begin
      m_cnt = 0; m_dir = ch; m_tc = 0; m_done = 0; m_wr = 0; m_wr2 = 0;
    end else if (ld != 0) begin
      m_cnt = (ldv > lim) ? lim : ldv; m_dir = ch; m_tc = 0; m_done = 0;
    end else if (m_done != 0) begin
      m_tc = 0;
    end else begin
      nd = (md == 2) ? m_dir : ch;
      m_tc = 0;
      if (e != 0) begin
        tgt = (m_dir != 0) ? 0 : lim;
        if (m_cnt > lim) begin
          m_cnt = lim; m_tc = 1;
        end else if (m_cnt != tgt) begin
          m_cnt = m_cnt + ((m_dir != 0) ? -1 : 1);
          m_tc = (m_cnt == tgt) ? 1 : 0;
        end else begin
          case (md)
            0: begin
              m_cnt = (m_dir != 0) ? lim : 0;
              m_wr = (m_wr < 255) ? m_wr + 1 : 255; m_wr2 = (m_wr2 < 3) ? m_wr2 + 1 : 3;
            end
            2: begin
              nd = (m_dir != 0) ? 0 : 1;
              m_cnt = (lim == 0) ? 0 : ((m_dir != 0) ? 1 : lim - 1);
              m_wr = (m_wr < 255) ? m_wr + 1 : 255; m_wr2 = (m_wr2 < 3) ? m_wr2 + 1 : 3;
            end
            3: m_done = 1;
            default: ;
          endcase
        end
      end
      m_dir = nd;
    end
  endtask

  initial begin
    logic [7:0] exp_w2;
    // rst ld ldv en ch lim md | cnt tc dir done wr
    // WRAP up
    add(1, 0,  0, 0, 0,  9, 0,  0, 0, 0, 0, 0);
    add(0, 1,  7, 0, 0,  9, 0,  7, 0, 0, 0, 0);
    add(0, 0,  0, 1, 0,  9, 0,  8, 0, 0, 0, 0);
    add(0, 0,  0, 1, 0,  9, 0,  9, 1, 0, 0, 0);
    add(0, 0,  0, 1, 0,  9, 0,  0, 0, 0, 0, 1);
    add(0, 0,  0, 1, 0,  9, 0,  1, 0, 0, 0, 1);
    // WRAP down with load clamp
    add(0, 1, 12, 0, 1,  5, 0,  5, 0, 1, 0, 1);
    add(0, 0,  0, 1, 1,  5, 0,  4, 0, 1, 0, 1);
    add(0, 0,  0, 1, 1,  5, 0,  3, 0, 1, 0, 1);
    add(0, 0,  0, 1, 1,  5, 0,  2, 0, 1, 0, 1);
    add(0, 0,  0, 1, 1,  5, 0,  1, 0, 1, 0, 1);
    add(0, 0,  0, 1, 1,  5, 0,  0, 1, 1, 0, 1);
    add(0, 0,  0, 1, 1,  5, 0,  5, 0, 1, 0, 2);
    // SAT and mid-run limit drop
    add(0, 1, 14, 0, 0, 15, 1, 14, 0, 0, 0, 2);
    add(0, 0,  0, 1, 0, 15, 1, 15, 1, 0, 0, 2);
    add(0, 0,  0, 1, 0, 15, 1, 15, 0, 0, 0, 2);
    add(0, 0,  0, 1, 0, 10, 1, 10, 1, 0, 0, 2);
    add(0, 0,  0, 1, 0, 10, 1, 10, 0, 0, 0, 2);
    // BOUNCE with chnge toggling
    add(0, 1,  0, 0, 0,  3, 2,  0, 0, 0, 0, 2);
    add(0, 0,  0, 1, 1,  3, 2,  1, 0, 0, 0, 2);
    add(0, 0,  0, 1, 0,  3, 2,  2, 0, 0, 0, 2);
    add(0, 0,  0, 1, 1,  3, 2,  3, 1, 0, 0, 2);
    add(0, 0,  0, 1, 0,  3, 2,  2, 0, 1, 0, 3);
    add(0, 0,  0, 1, 1,  3, 2,  1, 0, 1, 0, 3);
    add(0, 0,  0, 1, 0,  3, 2,  0, 1, 1, 0, 3);
    add(0, 0,  0, 1, 1,  3, 2,  1, 0, 0, 0, 4);
    // ONESHOT, then reset beats load
    add(0, 1,  2, 0, 0,  4, 3,  2, 0, 0, 0, 4);
    add(0, 0,  0, 1, 0,  4, 3,  3, 0, 0, 0, 4);
    add(0, 0,  0, 1, 0,  4, 3,  4, 1, 0, 0, 4);
    add(0, 0,  0, 1, 0,  4, 3,  4, 0, 0, 1, 4);
    add(0, 0,  0, 1, 1,  4, 3,  4, 0, 0, 1, 4);
    add(1, 1,  3, 0, 0,  4, 3,  0, 0, 0, 0, 0);
    // en low holds count and clears tc
    add(0, 1,  8, 0, 0,  9, 0,  8, 0, 0, 0, 0);
    add(0, 0,  0, 1, 0,  9, 0,  9, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 9, 0, 9, 0, 0, 0, 0);
    // limit 0: wraps on every step, saturates in the 2-bit instance
    add(1, 0,  0, 0, 1,  0, 0,  0, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, i);
    // ONESHOT with limit 0 ends on first step; mode change keeps ST_DONE
    add(0, 1,  0, 0, 0,  0, 3,  0, 0, 0, 0, 5);
    add(0, 0,  0, 1, 0,  0, 3,  0, 0, 0, 1, 5);
    add(0, 0,  0, 1, 0,  0, 0,  0, 0, 0, 1, 5);

    @(posedge CLK);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].ldv, vecs[i].en, vecs[i].ch, vecs[i].lim,
            vecs[i].md);
      check($sformatf("vec%0d", i), {8'h0, count, 3'b0, tc, 3'b0, dir, 3'b0, done, wraps},
            {8'h0, vecs[i].cnt, 3'b0, vecs[i].tc, 3'b0, vecs[i].dir, 3'b0, vecs[i].done,
             vecs[i].wr});
      exp_w2 = (vecs[i].wr > 8'd3) ? 8'd3 : vecs[i].wr;
      check($sformatf("vec%0d_w2", i),
            {8'h0, count2, 3'b0, tc2, 3'b0, dir2, 3'b0, done2, 6'b0, wraps2},
            {8'h0, vecs[i].cnt, 3'b0, vecs[i].tc, 3'b0, vecs[i].dir, 3'b0, vecs[i].done,
             exp_w2});
    end

    // Randomised run against the reference model
    begin
      int r_rst, r_ld, r_ldv, r_en, r_ch, r_lim, r_md;
      r_lim = 9; r_md = 0; r_ch = 0;
      for (int i = 0; i < 3000; i++) begin
        r_rst = (i == 0 || $urandom_range(63) == 0) ? 1 : 0;
        r_ld  = ($urandom_range(11) == 0) ? 1 : 0;
        r_ldv = $urandom_range(15);
        r_en  = ($urandom_range(3) != 0) ? 1 : 0;
        if ($urandom_range(5) == 0) r_ch = 1 - r_ch;
        if ($urandom_range(19) == 0) r_lim = $urandom_range(15);
        if ($urandom_range(29) == 0) r_md = $urandom_range(3);
        model(r_rst, r_ld, r_ldv, r_en, r_ch, r_lim, r_md);
        drive(1'(r_rst), 1'(r_ld), 4'(r_ldv), 1'(r_en), 1'(r_ch), 4'(r_lim), 2'(r_md));
        check($sformatf("rand%0d", i),
              {8'h0, count, 3'b0, tc, 3'b0, dir, 3'b0, done, wraps},
              {8'h0, 4'(m_cnt), 3'b0, 1'(m_tc), 3'b0, 1'(m_dir), 3'b0, 1'(m_done),
               8'(m_wr)});
        check($sformatf("rand%0d_w2", i),
              {8'h0, count2, 3'b0, tc2, 3'b0, dir2, 3'b0, done2, 6'b0, wraps2},
              {8'h0, 4'(m_cnt), 3'b0, 1'(m_tc), 3'b0, 1'(m_dir), 3'b0, 1'(m_done),
               8'(m_wr2)});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
